// File: rtl/adc_capture_ctrl_pkg.sv
// rfsoc_config: shared constants for the RFSoC converter channels.
// Holds gpio_ctrl bit indices, the capture FSM state type and width defaults.
package rfsoc_config;

    localparam int DATA_W_DEF  = 256;
    localparam int COUNT_W_DEF = 32;
    localparam int GPIO_W_DEF  = 16;

    // gpio_ctrl serial bus bit positions
    localparam int SDATA_BIT     = 0;
    localparam int MASK_CLK_BIT  = 1;
    localparam int COUNT_CLK_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/adc_capture_ctrl_gpio_shift_reg.sv
// gpio_shift_reg: W-bit config register loaded bit-serially from gpio_ctrl.
// Ports: clk, rst, strobe (shift clock bit), sdata, select_in -> q.
import rfsoc_config::*;

module gpio_shift_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         strobe,
    input  logic         sdata,
    input  logic         select_in,
    output logic [W-1:0] q
);

    logic strobe_q;
    logic shift_en;

    // rising edge of the registered strobe, qualified by channel select
    assign shift_en = strobe & ~strobe_q & select_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q <= 1'b0;
            q        <= '0;
        end else begin
            strobe_q <= strobe;
            if (shift_en)
                q <= {q[W-2:0], sdata};
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: triggered capture of a programmed number of ADC words
// into the capture FIFO, with sample-granular masking of first/last words.
// Ports: clk, rst, s_axis_* (ADC in), m_axis_* (FIFO out), gpio_ctrl,
// select_in, trigger_in, busy, overflow.
// Optional: ADC_CAPTURE_RETRIGGER_EN lets a trigger restart a capture.
import rfsoc_config::*;

module adc_capture_ctrl #(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int GPIO_W  = GPIO_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    input  logic [GPIO_W-1:0] gpio_ctrl,
    input  logic              select_in,
    input  logic              trigger_in,
    output logic              busy,
    output logic              overflow
);

    logic [DATA_W-1:0]  mask_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] remaining;
    logic               first;
    state_t             state;

    logic              accept;
    logic              retrig;
    logic              is_last;
    logic [DATA_W-1:0] word_out;

    gpio_shift_reg #(
        .W (DATA_W)
    ) u_mask (
        .clk       (clk),
        .rst       (rst),
        .strobe    (gpio_ctrl[MASK_CLK_BIT]),
        .sdata     (gpio_ctrl[SDATA_BIT]),
        .select_in (select_in),
        .q         (mask_q)
    );

    gpio_shift_reg #(
        .W (COUNT_W)
    ) u_count (
        .clk       (clk),
        .rst       (rst),
        .strobe    (gpio_ctrl[COUNT_CLK_BIT]),
        .sdata     (gpio_ctrl[SDATA_BIT]),
        .select_in (select_in),
        .q         (count_q)
    );

    // the ADC cannot be back-pressured
    assign s_axis_tready = 1'b1;

    assign busy   = (state != ST_IDLE);
    assign accept = (state == ST_CAPTURE) && s_axis_tvalid;

`ifdef ADC_CAPTURE_RETRIGGER_EN
    assign retrig = (state == ST_CAPTURE) && trigger_in;
`else
    assign retrig = 1'b0;
`endif

    // a retrigger closes the running record on the current word
    assign is_last = (remaining == COUNT_W'(1)) || retrig;

    always_comb begin
        word_out = s_axis_tdata;
        if (first)
            word_out = word_out & mask_q;
        if (is_last)
            word_out = word_out & ~mask_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            remaining     <= '0;
            first         <= 1'b0;
            overflow      <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            m_axis_tvalid <= accept;
            m_axis_tlast  <= accept && is_last;
            if (accept)
                m_axis_tdata <= word_out;

            // word presented for one cycle only; FIFO not ready drops it
            if (m_axis_tvalid && !m_axis_tready)
                overflow <= 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (trigger_in && count_q != '0) begin
                        remaining <= count_q;
                        first     <= 1'b1;
                        overflow  <= 1'b0;
                        state     <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (retrig) begin
                        if (count_q != '0) begin
                            remaining <= count_q;
                            first     <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else if (accept) begin
                        remaining <= remaining - COUNT_W'(1);
                        first     <= 1'b0;
                        if (remaining == COUNT_W'(1))
                            state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed self-checking bench for adc_capture_ctrl.
// Covers config shifting, masking, gaps, overflow, reset and retrigger.
import rfsoc_config::*;

module tb_adc_capture_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] s_tdata;
    logic         s_tvalid;
    logic         s_tready;
    logic [255:0] m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;
    logic [15:0]  gpio;
    logic         sel;
    logic         trig;
    logic         busy;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] LOW = 256'hFFFF;

    adc_capture_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .gpio_ctrl     (gpio),
        .select_in     (sel),
        .trigger_in    (trig),
        .busy          (busy),
        .overflow      (overflow)
    );

    always #2 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [255:0] ramp(input int k);
        logic [15:0] s;
        s = k[15:0];
        return {16{s}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input int cb, input logic b, input logic sl);
        gpio = '0;
        gpio[SDATA_BIT] = b;
        sel = sl;
        step();
        gpio[cb] = 1'b1;
        step();
        gpio = '0;
        sel = 1'b0;
    endtask

    task automatic shift_count(input logic [31:0] v, input logic sl);
        for (int i = 31; i >= 0; i--)
            shift_bit(COUNT_CLK_BIT, v[i], sl);
    endtask

    task automatic shift_mask(input logic [255:0] v, input logic sl);
        for (int i = 255; i >= 0; i--)
            shift_bit(MASK_CLK_BIT, v[i], sl);
    endtask

    task automatic pulse_trigger();
        trig = 1'b1;
        step();
        trig = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({m_tvalid, m_tlast, busy, overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000",
                     {m_tvalid, m_tlast, busy, overflow});
        end
        checks++;
        if (m_tdata !== '0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", m_tdata);
        end
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL s_tready got %b want 1", s_tready);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        logic [255:0] ed;
        shift_mask(LOW, 1'b1);
        shift_count(32'd4, 1'b1);
        pulse_trigger();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_start got %b want 1", busy);
        end
        for (int k = 1; k <= 6; k++) begin
            s_tdata = ramp(k);
            s_tvalid = 1'b1;
            step();
            ed = (k == 1) ? (ramp(1) & LOW) :
                 (k == 4) ? (ramp(4) & ~LOW) : ramp(k);
            checks++;
            if ({m_tvalid, m_tlast, busy} !==
                {k <= 4, k == 4, k <= 4}) begin
                errors++;
                $display("FAIL basic_flags k=%0d got %b want %b", k,
                         {m_tvalid, m_tlast, busy},
                         {k <= 4, k == 4, k <= 4});
            end
            if (k <= 4) begin
                checks++;
                if (m_tdata !== ed) begin
                    errors++;
                    $display("FAIL basic_data k=%0d got %h want %h",
                             k, m_tdata, ed);
                end
            end
        end
        s_tvalid = 1'b0;
        step();
    endtask

    task automatic test_zero_count();
        shift_count(32'd0, 1'b1);
        pulse_trigger();
        for (int k = 1; k <= 3; k++) begin
            s_tdata = ramp(k);
            s_tvalid = 1'b1;
            step();
            checks++;
            if ({m_tvalid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL zero_count k=%0d got %b want 00",
                         k, {m_tvalid, busy});
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic test_gaps();
        logic [4:0]   pat;
        logic [255:0] ed;
        pat = 5'b10101;
        shift_count(32'd3, 1'b1);
        pulse_trigger();
        for (int k = 1; k <= 5; k++) begin
            s_tdata = ramp(k);
            s_tvalid = pat[5-k];
            step();
            ed = (k == 1) ? (ramp(1) & LOW) :
                 (k == 5) ? (ramp(5) & ~LOW) : ramp(k);
            checks++;
            if ({m_tvalid, m_tlast, busy} !==
                {pat[5-k], k == 5, 1'b1}) begin
                errors++;
                $display("FAIL gaps_flags k=%0d got %b want %b", k,
                         {m_tvalid, m_tlast, busy},
                         {pat[5-k], k == 5, 1'b1});
            end
            if (pat[5-k]) begin
                checks++;
                if (m_tdata !== ed) begin
                    errors++;
                    $display("FAIL gaps_data k=%0d got %h want %h",
                             k, m_tdata, ed);
                end
            end
        end
        s_tvalid = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL gaps_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_overflow();
        int hs;
        hs = 0;
        shift_count(32'd5, 1'b1);
        m_tready = 1'b1;
        pulse_trigger();
        for (int k = 1; k <= 5; k++) begin
            s_tdata = ramp(k);
            s_tvalid = 1'b1;
            step();
            m_tready = (k == 3) ? 1'b0 : 1'b1;
            if (m_tvalid && m_tready)
                hs++;
            if (k == 4) begin
                checks++;
                if (overflow !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_set got %b want 1", overflow);
                end
            end
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        checks++;
        if (hs !== 4) begin
            errors++;
            $display("FAIL ovf_handshakes got %0d want 4", hs);
        end
        step();
        step();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b want 1", overflow);
        end
        pulse_trigger();
        checks++;
        if ({overflow, busy} !== 2'b01) begin
            errors++;
            $display("FAIL ovf_clear got %b want 01", {overflow, busy});
        end
        s_tvalid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            s_tdata = ramp(k);
            step();
        end
        s_tvalid = 1'b0;
        step();
    endtask

    task automatic test_single();
        shift_count(32'd1, 1'b1);
        pulse_trigger();
        s_tdata = ramp(7);
        s_tvalid = 1'b1;
        step();
        s_tvalid = 1'b0;
        checks++;
        if ({m_tvalid, m_tlast, busy} !== 3'b111 || m_tdata !== '0) begin
            errors++;
            $display("FAIL single got %b %h want 111 0",
                     {m_tvalid, m_tlast, busy}, m_tdata);
        end
        step();
        checks++;
        if ({m_tvalid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_end got %b want 00", {m_tvalid, busy});
        end
    endtask

    task automatic test_reset_mid();
        shift_count(32'd8, 1'b1);
        pulse_trigger();
        s_tdata = ramp(1);
        s_tvalid = 1'b1;
        step();
        s_tdata = ramp(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_tvalid = 1'b0;
        checks++;
        if ({m_tvalid, m_tlast, busy, overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_mid got %b want 0000",
                     {m_tvalid, m_tlast, busy, overflow});
        end
        pulse_trigger();
        s_tvalid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            s_tdata = ramp(k);
            step();
            checks++;
            if ({m_tvalid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL rst_mid_trig k=%0d got %b want 00",
                         k, {m_tvalid, busy});
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic test_select();
        shift_count(32'd2, 1'b0);
        shift_mask(LOW, 1'b0);
        pulse_trigger();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sel_count got busy %b want 0", busy);
        end
        shift_count(32'd2, 1'b1);
        pulse_trigger();
        s_tvalid = 1'b1;
        s_tdata = ramp(1);
        step();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== '0) begin
            errors++;
            $display("FAIL sel_mask_first got %b %h want 1 0",
                     m_tvalid, m_tdata);
        end
        s_tdata = ramp(2);
        step();
        s_tvalid = 1'b0;
        checks++;
        if ({m_tvalid, m_tlast} !== 2'b11 || m_tdata !== ramp(2)) begin
            errors++;
            $display("FAIL sel_mask_last got %b %h want 11 %h",
                     {m_tvalid, m_tlast}, m_tdata, ramp(2));
        end
        step();
    endtask

    task automatic test_retrigger();
        logic [255:0] ed;
        logic         ev;
        logic         el;
        shift_mask(LOW, 1'b1);
        shift_count(32'd4, 1'b1);
        pulse_trigger();
        s_tvalid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            s_tdata = ramp(k);
            trig = (k == 2);
            step();
`ifdef ADC_CAPTURE_RETRIGGER_EN
            ev = 1'b1;
            el = (k == 2) || (k == 6);
            ed = (k == 1 || k == 3) ? (ramp(k) & LOW) :
                 (k == 2 || k == 6) ? (ramp(k) & ~LOW) : ramp(k);
`else
            ev = (k <= 4);
            el = (k == 4);
            ed = (k == 1) ? (ramp(1) & LOW) :
                 (k == 4) ? (ramp(4) & ~LOW) : ramp(k);
`endif
            checks++;
            if ({m_tvalid, m_tlast} !== {ev, el}) begin
                errors++;
                $display("FAIL retrig_flags k=%0d got %b want %b", k,
                         {m_tvalid, m_tlast}, {ev, el});
            end
            if (ev) begin
                checks++;
                if (m_tdata !== ed) begin
                    errors++;
                    $display("FAIL retrig_data k=%0d got %h want %h",
                             k, m_tdata, ed);
                end
            end
        end
        trig = 1'b0;
        s_tvalid = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL retrig_end busy got %b want 0", busy);
        end
    endtask

    initial begin
        rst = 1'b1;
        s_tdata = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        gpio = '0;
        sel = 1'b0;
        trig = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_single();
        test_zero_count();
        test_reset_mid();
        test_select();
        test_retrigger();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
